imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-stream program loader that writes instruction words into the beta instruction memory, the write side of the port the CPU fetches from. It holds the CPU in reset while loading and releases it only after a verified, complete image. It sits between a host byte link and the im write port, so programs can be loaded in hardware rather than only from a memory-init file.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width; capacity = 2^ADDR_WIDTH words.
WORD_BYTES, 4, bytes per instruction word; fixed at 4, other values unsupported.

Ports:
clk  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
im_we  output  1  instruction memory write enable, one cycle per word
im_waddr  output  ADDR_WIDTH  word address of the write
im_wdata  output  32  instruction word
cpu_hold  output  1  active-high; drives the beta RESET input
done  output  1  image loaded and checksum verified
error  output  1  load aborted
words_loaded  output  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Reset (RESET=0, async): state IDLE, cpu_hold=1, byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, done=0, error=0, words_loaded=0, checksum accumulator=0.
- Handshake: a byte is accepted on a rising edge when byte_valid=1 and byte_ready=1. byte_ready=1 only in LEN_HI, LEN_LO, DATA and CHECK. The loader never stalls inside those states.
- Frame format: N[15:8], N[7:0], then N*4 data bytes with each word MSB first, then one checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.
- IDLE: start -> LEN_HI. On entry from any state, clear done, error, words_loaded and the checksum, and set cpu_hold=1.
- LEN_HI: accept the byte into N[15:8] -> LEN_LO.
- LEN_LO: accept the byte into N[7:0]. If N==0 or N>2^ADDR_WIDTH, go to ERR. Otherwise go to DATA.
- DATA:
  - Shift each accepted byte into the word register, MSB first, and XOR it into the checksum.
  - On the 4th byte, in the next cycle: im_we=1 for exactly one cycle, im_waddr=words_loaded (old value), im_wdata=assembled word; words_loaded increments in that same cycle.
  - After word N is accepted -> CHECK. The write for word N still issues in the following cycle.
- CHECK: accept one byte. If it equals the checksum -> DONE, else -> ERR.
- DONE: done=1, cpu_hold=0 (CPU released the cycle after the checksum byte is accepted). start -> LEN_HI, with cpu_hold reasserted the same cycle.
- ERR: error=1, cpu_hold=1, byte_ready=0. start -> LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- Words already written before an error remain in memory; the CPU is never released on error.
- Reset mid-load: immediate return to IDLE. Any pending partial word is discarded and no im_we is issued after reset.
- im_waddr is the low ADDR_WIDTH bits of the word index. It never wraps, because N is bounded by capacity.

Test Plan:
- Reset, then start; stream 00 02 11 22 33 44 A5 A5 A5 A5 44 -> im_we pulses at addr 0 with 0x11223344 and at addr 1 with 0xA5A5A5A5; words_loaded=2; done=1; cpu_hold=0 one cycle after the 0x44 is accepted.
- Same frame with checksum 0x45 -> both writes occur; error=1, done=0, cpu_hold stays 1, byte_ready=0.
- Length 00 00, and separately 01 01 with ADDR_WIDTH=8 -> ERR immediately after the second length byte; no im_we.
- Frame with byte_valid gaps of 0-3 random idle cycles -> same writes as the first scenario; no byte is duplicated or lost; im_we stays one cycle per word.
- Drop RESET to 0 after 6 data bytes of a 2-word frame -> outputs take their reset values asynchronously; exactly one write (addr 0) was issued; a full reload afterwards succeeds.
- From DONE, pulse start and load 00 01 DE AD BE EF 22 -> cpu_hold rises with start; addr 0 is written with 0xDEADBEEF; done=1 again.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the beta instruction memory: parses a length-prefixed,
// XOR-checksummed frame into im write cycles and holds the CPU until the image verifies.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_waddr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned BCW = $clog2(WORD_BYTES);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           word_q, word_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [7:0]            chk_q, chk_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   wl_q, wl_d;
    logic                  accept;
    logic [15:0]           n_full;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            len_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            chk_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
        byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CHECK);
        accept  = byte_ready && byte_valid;
        n_full  = {len_q[15:8], byte_in};

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    wl_d    = '0;
                    chk_d   = '0;
                    bcnt_d  = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_in;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_in;
                    bcnt_d     = '0;
                    if (n_full == 16'd0 || {1'b0, n_full} > CAPACITY) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d = {word_q[15:0], byte_in};
                    chk_d  = chk_q ^ byte_in;
                    bcnt_d = bcnt_q + BCW'(1);
                    // Write is registered so it lands the cycle after the last byte,
                    // with words_loaded advancing alongside it.
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        we_d    = 1'b1;
                        waddr_d = wl_q[ADDR_WIDTH-1:0];
                        wdata_d = {word_q, byte_in};
                        wl_d    = wl_q + 1'b1;
                        if (17'(wl_q) + 17'd1 == {1'b0, len_q}) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (byte_in == chk_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign im_we        = we_q;
    assign im_waddr     = waddr_q;
    assign im_wdata     = wdata_q;
    assign words_loaded = wl_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign cpu_hold     = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from word lists, expected
// writes are queued up front and a negedge monitor matches every im_we pulse.
module tb_imem_loader;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          RESET = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(4)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] frame_words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every im_we pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (im_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write addr %0h data %0h, expected none", im_waddr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", 64'(im_waddr), 64'(mon_e.addr));
                check("wdata", 64'(im_wdata), 64'(mon_e.data));
                check("words_loaded_at_write", 64'(words_loaded), 64'(mon_e.addr) + 64'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals();
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_waddr", 64'(im_waddr), 64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned maxgap, input bit noise);
        int unsigned gap;
        int cnt;
        gap = $urandom_range(maxgap, 0);
        cnt = 0;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = b;
        start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        while (byte_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte_ready=%0b, expected 1", byte_ready);
        end else begin
            @(posedge clk);
        end
        #1;
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_hold", 64'(cpu_hold), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check("start_error", 64'(error), 64'd0);
        check("start_words_loaded", 64'(words_loaded), 64'd0);
        check("start_byte_ready", 64'(byte_ready), 64'd1);
    endtask

    // Reference: length legal iff 1..2^AW, checksum is XOR of data bytes only.
    task automatic run_frame(input logic [15:0] n, input logic [7:0] flip,
                             input int unsigned maxgap, input bit noise);
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        bit          lenok;
        bit          exp_done;
        lenok = (n != 16'd0) && (int'(n) <= (1 << AW));
        exp_done = lenok && (flip == 8'd0);
        x = '0;
        if (lenok) begin
            foreach (frame_words[i]) begin
                w = frame_words[i];
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                e.addr = AW'(i);
                e.data = w;
                exp_q.push_back(e);
            end
        end
        pulse_start();
        send_byte(n[15:8], maxgap, noise);
        send_byte(n[7:0], maxgap, noise);
        if (lenok) begin
            foreach (frame_words[i]) begin
                w = frame_words[i];
                send_byte(w[31:24], maxgap, noise);
                send_byte(w[23:16], maxgap, noise);
                send_byte(w[15:8], maxgap, noise);
                send_byte(w[7:0], maxgap, noise);
            end
            send_byte(x ^ flip, maxgap, noise);
        end
        @(negedge clk);
        check("end_done", 64'(done), 64'(exp_done));
        check("end_error", 64'(error), 64'(!exp_done));
        check("end_cpu_hold", 64'(cpu_hold), 64'(!exp_done));
        check("end_byte_ready", 64'(byte_ready), 64'd0);
        check("end_words_loaded", 64'(words_loaded), lenok ? 64'(n) : 64'd0);
        check("end_pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        wr_t e;
        #12;
        check_reset_vals();
        @(negedge clk);
        RESET = 1'b1;

        frame_words = '{32'h11223344, 32'hA5A5A5A5};
        run_frame(16'd2, 8'h00, 0, 0);
        run_frame(16'd2, 8'h01, 0, 0);

        frame_words.delete();
        run_frame(16'h0000, 8'h00, 0, 0);
        run_frame(16'h0101, 8'h00, 0, 0);

        frame_words = '{32'h11223344, 32'hA5A5A5A5};
        run_frame(16'd2, 8'h00, 3, 0);

        e.addr = '0;
        e.data = 32'h11223344;
        exp_q.push_back(e);
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        send_byte(8'h44, 0, 0);
        send_byte(8'hA5, 0, 0);
        send_byte(8'hA5, 0, 0);
        @(negedge clk);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_vals();
        check("reset_pending_writes", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        RESET = 1'b1;
        run_frame(16'd2, 8'h00, 1, 0);

        frame_words = '{32'hDEADBEEF};
        run_frame(16'd1, 8'h00, 0, 0);

        for (int k = 0; k < 6; k++) begin
            int unsigned nn;
            logic [7:0]  fl;
            nn = $urandom_range(12, 1);
            frame_words.delete();
            repeat (nn) frame_words.push_back($urandom);
            fl = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_frame(16'(nn), fl, 3, 1);
        end

        frame_words.delete();
        repeat (1 << AW) frame_words.push_back($urandom);
        run_frame(16'(1 << AW), 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
